// File: rtl/fractcam_pkg.sv
// Shared SRL array geometry, readback FSM state encoding and sweep-size helper.
// Used by both the SRL fill-side counter and srl_readback.
package fractcam_pkg;

  localparam int NUM_SRL_DEF   = 8;
  localparam int SRL_DEPTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_OUT    = 3'd3,
    ST_DONE   = 3'd4
  } rb_state_t;

  function automatic int beats_per_sweep(input int num_srl, input int srl_depth, input int out_w);
    return (num_srl * srl_depth) / out_w;
  endfunction

endpackage

// File: rtl/srl_rb_packer.sv
// MSB-first shift/pack register for srl_readback: collects OUT_W sampled bits into one beat.
// Optional SRL_RB_PARITY_EN adds a parity bit registered alongside the packed word.
module srl_rb_packer #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [OUT_W-1:0] pack,
`ifdef SRL_RB_PARITY_EN
  output logic             par,
`endif
  output logic             full
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] pack_next;

  assign pack_next = {pack[OUT_W-2:0], bit_in};
  // full flags the shift that completes a beat, so the FSM can move to OUT in the same cycle.
  assign full      = shift && (cnt == CNT_W'(OUT_W - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack <= '0;
      cnt  <= '0;
`ifdef SRL_RB_PARITY_EN
      par  <= 1'b0;
`endif
    end else if (clear) begin
      cnt <= '0;
    end else if (shift) begin
      pack <= pack_next;
      cnt  <= full ? '0 : CNT_W'(cnt + 1'b1);
`ifdef SRL_RB_PARITY_EN
      par  <= ^pack_next;
`endif
    end
  end

endmodule

// File: rtl/srl_readback.sv
// Sweeps every SRL tap (sel ascending, addr descending) and streams the bits as OUT_W-bit beats.
// Define SRL_RB_PARITY_EN to add the m_par output (^m_data, valid with m_valid).
module srl_readback
  import fractcam_pkg::*;
#(
  parameter  int NUM_SRL   = NUM_SRL_DEF,
  parameter  int SRL_DEPTH = SRL_DEPTH_DEF,
  parameter  int OUT_W     = 8,
  parameter  int RD_LAT    = 1,
  localparam int SEL_W     = $clog2(NUM_SRL),
  localparam int ADDR_W    = $clog2(SRL_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               wr,
  output logic [SEL_W-1:0]   srl_sel,
  output logic [ADDR_W-1:0]  srl_addr,
  input  logic [NUM_SRL-1:0] srl_q,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
`ifdef SRL_RB_PARITY_EN
  output logic               m_par,
`endif
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int          LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(SRL_DEPTH - 1);
  localparam int          NUM_BEATS = beats_per_sweep(NUM_SRL, SRL_DEPTH, OUT_W);
  // With a combinational SRL output there is nothing to wait for, so SETUP is bypassed.
  localparam rb_state_t   FETCH_ST = (RD_LAT == 0) ? ST_SAMPLE : ST_SETUP;

  rb_state_t         state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SEL_W-1:0]  adv_sel;
  logic [ADDR_W-1:0] adv_addr;
  logic              is_last;
  logic              shift;
  logic              full;

  // Address descends because the oldest written bit sits at the highest tap.
  always_comb begin
    adv_sel  = srl_sel;
    adv_addr = srl_addr - 1'b1;
    if (srl_addr == '0) begin
      adv_sel  = srl_sel + 1'b1;
      adv_addr = ADDR_TOP;
    end
  end

  assign is_last = (srl_sel == SEL_W'(NUM_SRL - 1)) && (srl_addr == '0);
  assign shift   = (state == ST_SAMPLE) && !wr;

  srl_rb_packer #(.OUT_W(OUT_W)) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_IDLE),
    .shift  (shift),
    .bit_in (srl_q[srl_sel]),
    .pack   (m_data),
`ifdef SRL_RB_PARITY_EN
    .par    (m_par),
`endif
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      srl_sel  <= '0;
      srl_addr <= ADDR_TOP;
      lat_cnt  <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if ((state != ST_IDLE) && wr) begin
        // A fill write corrupts the sweep: drop everything, including an unaccepted beat.
        state    <= ST_IDLE;
        srl_sel  <= '0;
        srl_addr <= ADDR_TOP;
        lat_cnt  <= '0;
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
        busy     <= 1'b0;
        err      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && wr) begin
              err <= 1'b1;
            end else if (start) begin
              state    <= FETCH_ST;
              busy     <= 1'b1;
              srl_sel  <= '0;
              srl_addr <= ADDR_TOP;
              lat_cnt  <= '0;
            end
          end
          ST_SETUP: begin
            if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
              state   <= ST_SAMPLE;
              lat_cnt <= '0;
            end else begin
              lat_cnt <= LAT_W'(lat_cnt + 1'b1);
            end
          end
          ST_SAMPLE: begin
            if (full) begin
              state   <= ST_OUT;
              m_valid <= 1'b1;
              m_last  <= is_last;
            end else begin
              state    <= FETCH_ST;
              srl_sel  <= adv_sel;
              srl_addr <= adv_addr;
            end
          end
          ST_OUT: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (is_last) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                srl_sel  <= '0;
                srl_addr <= ADDR_TOP;
              end else begin
                state    <= FETCH_ST;
                srl_sel  <= adv_sel;
                srl_addr <= adv_addr;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Only referenced to keep the sweep-size helper tied to the geometry actually built.
  logic unused_ok;
  assign unused_ok = (NUM_BEATS > 0);

endmodule

// File: tb/tb_srl_readback.sv
// Self-checking bench for srl_readback: behavioural SRL array filled with bytes 0x00..0x1F.
// Build with SRL_RB_PARITY_EN to exercise m_par with a combinational (RD_LAT=0) SRL model.
module tb_srl_readback;

`ifdef SRL_RB_PARITY_EN
  localparam int RD_LAT    = 0;
  localparam int SWEEP_CYC = 288;
`else
  localparam int RD_LAT    = 1;
  localparam int SWEEP_CYC = 544;
`endif
  localparam int NBEATS = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       wr = 1'b0;
  logic       m_ready = 1'b1;
  logic [2:0] srl_sel;
  logic [4:0] srl_addr;
  logic [7:0] srl_q;
  logic [7:0] m_data;
  logic       m_valid, m_last, busy, done, err;
`ifdef SRL_RB_PARITY_EN
  logic       m_par;
`endif

  srl_readback #(.NUM_SRL(8), .SRL_DEPTH(32), .OUT_W(8), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr       (wr),
    .srl_sel  (srl_sel),
    .srl_addr (srl_addr),
    .srl_q    (srl_q),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
`ifdef SRL_RB_PARITY_EN
    .m_par    (m_par),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  int err_seen = 0;
  int cyc      = 0;
  logic [31:0] srl_mem [8];
  logic [7:0]  exp_beats [NBEATS];
  logic [7:0]  q_comb, q_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRL array model: every SRL presents the tap at srl_addr, optionally one cycle late.
  always_comb begin
    q_comb = '0;
    for (int s = 0; s < 8; s++) q_comb[s] = srl_mem[s][srl_addr];
  end
  always_ff @(posedge clk) q_reg <= q_comb;
  assign srl_q = (RD_LAT == 0) ? q_comb : q_reg;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (err) err_seen++;

  // Stream checker: every valid beat must be the next one of the original write order.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid) begin
        if (exp_idx < NBEATS) begin
          check("m_data", m_data, exp_beats[exp_idx]);
          check("m_last", m_last, exp_idx == NBEATS - 1);
`ifdef SRL_RB_PARITY_EN
          check("m_par", m_par, ^exp_beats[exp_idx]);
`endif
        end else begin
          check("extra_beat", exp_idx, NBEATS - 1);
        end
        if (m_ready) exp_idx++;
      end else if (m_last) begin
        check("m_last_without_valid", m_last, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin tick(); n++; end
    check("done_seen", done, 1);
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    while (!(m_valid && exp_idx == idx) && n < 5000) begin tick(); n++; end
    check("beat_reached", m_valid && exp_idx == idx, 1);
  endtask

  initial begin
    int t0, t_done;
    logic [7:0] beat;
    logic       b;

    // Fill: byte stream 0x00..0x1F MSB-first, 32 shifts into each SRL in turn (tap 0 is the input).
    for (int s = 0; s < 8; s++) srl_mem[s] = '0;
    for (int k = 0; k < 256; k++) begin
      beat = 8'(k / 8);
      b    = beat[7 - (k % 8)];
      srl_mem[k / 32] = {srl_mem[k / 32][30:0], b};
    end
    // Expected stream: the k-th bit written is the one now at tap 31-(k%32) of SRL k/32.
    for (int i = 0; i < NBEATS; i++) begin
      beat = '0;
      for (int j = 0; j < 8; j++)
        beat = {beat[6:0], srl_mem[(i * 8 + j) / 32][31 - ((i * 8 + j) % 32)]};
      exp_beats[i] = beat;
    end
    check("model_beat0", exp_beats[0], 8'h00);
    check("model_beat3", exp_beats[3], 8'h03);
    check("model_beat31", exp_beats[31], 8'h1F);
    check("model_par7", ^exp_beats[7], 1);

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_addr", srl_addr, 31);
    check("rst_sel", srl_sel, 0);
    check("rst_data", m_data, 0);
    reset = 1'b0;
    tick();

    // 1: free-running sweep.
    exp_idx = 0; err_seen = 0;
    start_sweep(t0);
    check("busy_after_start", busy, 1);
    wait_done();
    t_done = cyc;
    check("sweep_cycles", t_done - t0, SWEEP_CYC);
    check("beats_seen", exp_idx, NBEATS);
    check("busy_at_done", busy, 0);
    check("addr_at_done", srl_addr, 31);
    tick();
    check("done_pulse", done, 0);
    check("no_err", err_seen, 0);

    // 2: stall beat 3 for 10 cycles.
    exp_idx = 0;
    start_sweep(t0);
    wait_beat(3);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, 8'h03);
      check("stall_addr", srl_addr, 0);
      check("stall_sel", srl_sel, 0);
    end
    m_ready = 1'b1;
    wait_done();
    check("stall_cycles", cyc - t0, SWEEP_CYC + 10);
    check("stall_beats", exp_idx, NBEATS);
    tick();

    // 3: abort with wr during beat 10, then rerun.
    exp_idx = 0; err_seen = 0;
    start_sweep(t0);
    wait_beat(10);
    wr = 1'b1;
    tick();
    wr = 1'b0;
    check("abort_err", err, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", m_valid, 0);
    tick();
    check("abort_err_pulse", err, 0);
    exp_idx = 0;
    start_sweep(t0);
    wait_done();
    check("rerun_beats", exp_idx, NBEATS);
    check("rerun_err_count", err_seen, 1);
    tick();

    // 4: start with wr in IDLE is rejected; start while busy is ignored.
    wr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 1'b0;
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    tick();
    check("rej_err_pulse", err, 0);
    check("rej_still_idle", busy, 0);
    exp_idx = 0;
    start_sweep(t0);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("restart_ignored_cycles", cyc - t0, SWEEP_CYC);
    check("restart_ignored_beats", exp_idx, NBEATS);
    tick();

    // 5: reset in the middle of a stalled OUT.
    exp_idx = 0;
    start_sweep(t0);
    wait_beat(5);
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_sel", srl_sel, 0);
    check("mid_rst_addr", srl_addr, 31);
    reset = 1'b0;
    m_ready = 1'b1;
    tick();
    exp_idx = 0;
    start_sweep(t0);
    wait_done();
    check("post_rst_beats", exp_idx, NBEATS);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
